div_32: RTL

Sequential 32-bit signed integer divider for the ALU, producing quotient on `Zlow` and remainder on `Zhigh`, so the Z-register write path matches the other ALU operations. It is the multi-cycle counterpart to the single-cycle combinational ALU ops. It uses a start/busy/done handshake with the control unit, which holds the operands and waits for `done` before latching Z.

---
 rtl/div_32_pkg.sv | 20 ++
 rtl/div_step.sv | 28 ++
 rtl/div_32.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div_32_pkg.sv
// Shared definitions for the sequential signed divider: datapath width, FSM states,
// iteration counter type and a magnitude helper.
package div_32_pkg;

    localparam int unsigned Width = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFixup
    } state_e;

    typedef logic [4:0] count_t;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
    function automatic logic [Width-1:0] abs_val(input logic [Width-1:0] v);
        return v[Width-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left and conditionally subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        // A fitting subtraction always lands below 2^WIDTH, so the low bits are exact.
        diff    = shifted[WIDTH-1:0] - divisor_i;
        if (shifted >= {1'b0, divisor_i}) begin
            rem_o = diff;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_32.sv
// Sequential 32-bit signed divider: quotient on Zlow, remainder on Zhigh, with a
// start/busy/done handshake and an immediate divide-by-zero result.
module div_32
    import div_32_pkg::*;
#(
    parameter int unsigned WIDTH = Width
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] Zlow,
    output logic [WIDTH-1:0] Zhigh,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    count_t           count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] zlow_q, zlow_d;
    logic [WIDTH-1:0] zhigh_q, zhigh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zlow_d  = zlow_q;
        zhigh_d = zhigh_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (y == '0) begin
                        zlow_d  = '1;
                        zhigh_d = x;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                    end else begin
                        dvsr_d  = abs_val(y);
                        quo_d   = abs_val(x);
                        rem_d   = '0;
                        count_d = '0;
                        q_neg_d = x[WIDTH-1] ^ y[WIDTH-1];
                        r_neg_d = x[WIDTH-1];
                        dbz_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = StIter;
                    end
                end
            end
            StIter: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                zlow_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
                zhigh_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zlow_q  <= '0;
            zhigh_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zlow_q  <= zlow_d;
            zhigh_q <= zhigh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Zlow        = zlow_q;
    assign Zhigh       = zhigh_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
